// File: rtl/shift_op_sequencer.sv
// -----------------------------------------------------------------------------
// shift_op_sequencer
//
// Drives a combinational arithmetic-right / left barrel shifter through one to
// three registered passes to build SLL, SRA, SRL and ROL. Commands and results
// move over two independent valid/ready handshakes.
//
// Ports
//   CLK, RST_N        clock, synchronous active-low reset
//   REQ_VALID/READY   command handshake; REQ_OP, REQ_AMT, REQ_DATA payload
//                     (op: 00 SLL, 01 SRA, 10 SRL, 11 ROL)
//   RSP_VALID/READY   result handshake; RSP_DATA held until consumed
//   BS_DIR/AMT/DIN    to shifter (DIR 1 = arithmetic right, 0 = left)
//   BS_DOUT           from shifter, combinational from BS_*
// -----------------------------------------------------------------------------
module shift_op_sequencer #(
  parameter int IWIDTH = 32,
  parameter int SWIDTH = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_OP,
  input  logic [SWIDTH-1:0] REQ_AMT,
  input  logic [IWIDTH-1:0] REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [IWIDTH-1:0] RSP_DATA,
  output logic              BS_DIR,
  output logic [SWIDTH-1:0] BS_AMT,
  output logic [IWIDTH-1:0] BS_DIN,
  input  logic [IWIDTH-1:0] BS_DOUT
);

  typedef enum logic [2:0] {IDLE, P1, P2, P3, RESP} state_e;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRA = 2'b01,
                            OP_SRL = 2'b10, OP_ROL = 2'b11} op_e;

  // Only the MSB set: an arithmetic right shift of this smears it into a mask
  // whose top n+1 bits are ones.
  localparam logic [IWIDTH-1:0] MSB_ONLY = {1'b1, {(IWIDTH-1){1'b0}}};

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [SWIDTH-1:0]   n_q, n_d;
  logic [IWIDTH-1:0]   x_q, x_d;
  logic [IWIDTH-1:0]   acc_q, acc_d;
  logic [IWIDTH-1:0]   t_q, t_d;
  logic [IWIDTH-1:0]   m_q, m_d;
  logic [IWIDTH-1:0]   rsp_q, rsp_d;
  logic [SWIDTH-1:0]   k;

  // Complementary amount for the right-hand half of a rotate; wraps modulo
  // 2^SWIDTH, so it is only meaningful for n != 0.
  assign k = SWIDTH'(IWIDTH) - n_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statement leaves a value unassigned, which would infer a latch.
    state_d = state_q;
    op_d    = op_q;
    n_d     = n_q;
    x_d     = x_q;
    acc_d   = acc_q;
    t_d     = t_q;
    m_d     = m_q;
    rsp_d   = rsp_q;
    BS_DIR  = 1'b0;
    BS_AMT  = '0;
    BS_DIN  = '0;

    unique case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          op_d    = op_e'(REQ_OP);
          n_d     = REQ_AMT;
          x_d     = REQ_DATA;
          state_d = P1;
        end
      end

      P1: begin
        BS_DIR = (op_q == OP_SRA) || (op_q == OP_SRL);
        BS_AMT = n_q;
        BS_DIN = x_q;
        if ((op_q == OP_SRL) || ((op_q == OP_ROL) && (n_q != '0))) begin
          acc_d   = BS_DOUT;
          state_d = P2;
        end else begin
          // SLL, SRA and a zero-amount rotate finish in a single pass.
          rsp_d   = BS_DOUT;
          state_d = RESP;
        end
      end

      P2: begin
        BS_DIR = 1'b1;
        if (op_q == OP_SRL) begin
          // Mask pass: clear the n sign-fill bits left by the arithmetic shift.
          BS_AMT  = n_q;
          BS_DIN  = MSB_ONLY;
          m_d     = BS_DOUT;
          rsp_d   = acc_q & ~(BS_DOUT << 1);
          state_d = RESP;
        end else begin
          BS_AMT  = k;
          BS_DIN  = x_q;
          t_d     = BS_DOUT;
          state_d = P3;
        end
      end

      P3: begin
        // Mask for the rotate's wrapped-around bits: low n bits of t survive.
        BS_DIR  = 1'b1;
        BS_AMT  = k;
        BS_DIN  = MSB_ONLY;
        m_d     = BS_DOUT;
        rsp_d   = acc_q | (t_q & ~(BS_DOUT << 1));
        state_d = RESP;
      end

      RESP: begin
        if (RSP_READY) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      op_q    <= OP_SLL;
      n_q     <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      t_q     <= '0;
      m_q     <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n_q     <= n_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      t_q     <= t_d;
      m_q     <= m_d;
      rsp_q   <= rsp_d;
    end
  end

  // Ready is withheld while reset is asserted even though the state is IDLE.
  assign REQ_READY = (state_q == IDLE) && RST_N;
  assign RSP_VALID = (state_q == RESP);
  assign RSP_DATA  = rsp_q;

endmodule

// File: tb/tb_shift_op_sequencer.sv
module tb_shift_op_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [1:0]  REQ_OP;
  logic [4:0]  REQ_AMT;
  logic [31:0] REQ_DATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic        BS_DIR;
  logic [4:0]  BS_AMT;
  logic [31:0] BS_DIN;
  logic [31:0] BS_DOUT;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] SLL = 2'b00, SRA = 2'b01, SRL = 2'b10, ROL = 2'b11;

  always #5 CLK = ~CLK;

  // Reference model of the downstream combinational barrel shifter.
  assign BS_DOUT = BS_DIR ? 32'($signed(BS_DIN) >>> BS_AMT) : (BS_DIN << BS_AMT);

  shift_op_sequencer dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_AMT(REQ_AMT), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .BS_DIR(BS_DIR), .BS_AMT(BS_AMT), .BS_DIN(BS_DIN), .BS_DOUT(BS_DOUT)
  );

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_bs_idle(input string name);
    check({name, "_bs_dir"}, 32'(BS_DIR), 32'd0);
    check({name, "_bs_amt"}, 32'(BS_AMT), 32'd0);
    check({name, "_bs_din"}, BS_DIN, 32'd0);
  endtask

  // Waits (bounded) for REQ_READY, then offers one command; returns just after
  // the acceptance edge with REQ_VALID dropped.
  task automatic send(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] data);
    int w = 0;
    @(negedge CLK);
    while (!REQ_READY && w < 20) begin
      @(negedge CLK);
      w++;
    end
    check("send_req_ready", 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1;
    REQ_OP    = op;
    REQ_AMT   = amt;
    REQ_DATA  = data;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  // Counts negedges after acceptance until RSP_VALID; 1 = the cycle after.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!RSP_VALID && lat < 20);
  endtask

  task automatic handshake_rsp();
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] got;

    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_OP = '0; REQ_AMT = '0; REQ_DATA = '0;
    RSP_READY = 1'b0;

    vecs.push_back('{SLL, 5'd31, 32'h0000_0001, 32'h8000_0000, 2});
    vecs.push_back('{SLL, 5'd0,  32'h0000_0001, 32'h0000_0001, 2});
    vecs.push_back('{SRA, 5'd4,  32'h8000_0000, 32'hF800_0000, 2});
    vecs.push_back('{SRA, 5'd30, 32'h4000_0000, 32'h0000_0001, 2});
    vecs.push_back('{SRA, 5'd16, 32'h7FFF_0000, 32'h0000_7FFF, 2});
    vecs.push_back('{SRL, 5'd4,  32'h8000_0000, 32'h0800_0000, 3});
    vecs.push_back('{SRL, 5'd0,  32'h8000_0000, 32'h8000_0000, 3});
    vecs.push_back('{SRL, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 3});
    vecs.push_back('{SRL, 5'd8,  32'hF0F0_F0F0, 32'h00F0_F0F0, 3});
    vecs.push_back('{ROL, 5'd4,  32'h8000_0001, 32'h0000_0018, 4});
    vecs.push_back('{ROL, 5'd0,  32'h8000_0001, 32'h8000_0001, 2});
    vecs.push_back('{ROL, 5'd31, 32'h8000_0001, 32'hC000_0000, 4});
    vecs.push_back('{ROL, 5'd1,  32'h8000_0001, 32'h0000_0003, 4});
    vecs.push_back('{ROL, 5'd8,  32'h1234_5678, 32'h3456_7812, 4});

    // Reset state, sampled while RST_N is still low.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", 32'(REQ_READY), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_data",  RSP_DATA, 32'd0);
    check_bs_idle("rst");
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_rst_req_ready", 32'(REQ_READY), 32'd1);

    // Table-driven vectors: result, latency, idle shifter drive in RESP and
    // REQ_READY back the cycle after the response handshake.
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].op, vecs[i].amt, vecs[i].data);
      wait_rsp(lat);
      check($sformatf("vec%0d_data", i), RSP_DATA, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_ready_busy", i), 32'(REQ_READY), 32'd0);
      check_bs_idle($sformatf("vec%0d_resp", i));
      handshake_rsp();
      @(negedge CLK);
      check($sformatf("vec%0d_ready_after", i), 32'(REQ_READY), 32'd1);
      check($sformatf("vec%0d_valid_after", i), 32'(RSP_VALID), 32'd0);
    end

    // Backpressure: response held 5 cycles while another command waits.
    send(SRL, 5'd4, 32'h8000_0000);
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'd3);
    REQ_VALID = 1'b1; REQ_OP = SLL; REQ_AMT = 5'd2; REQ_DATA = 32'h0000_0003;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_c%0d", c), 32'(RSP_VALID), 32'd1);
      check($sformatf("bp_data_c%0d", c), RSP_DATA, 32'h0800_0000);
      check($sformatf("bp_ready_c%0d", c), 32'(REQ_READY), 32'd0);
      @(negedge CLK);
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
    @(negedge CLK);
    check("bp_ready_release", 32'(REQ_READY), 32'd1);
    check("bp_valid_release", 32'(RSP_VALID), 32'd0);
    // The waiting command is taken at the next edge.
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    wait_rsp(lat);
    check("bp_next_data", RSP_DATA, 32'h0000_000C);
    check("bp_next_lat", 32'(lat), 32'd2);
    handshake_rsp();

    // RSP_READY high in advance still yields a visible RSP_VALID cycle.
    RSP_READY = 1'b1;
    send(SRA, 5'd1, 32'hC000_0000);
    wait_rsp(lat);
    check("pre_ready_valid", 32'(RSP_VALID), 32'd1);
    check("pre_ready_data", RSP_DATA, 32'hE000_0000);
    check("pre_ready_lat", 32'(lat), 32'd2);
    @(posedge CLK);
    #1 RSP_READY = 1'b0;

    // Reset during ROL pass P2.
    send(ROL, 5'd4, 32'h8000_0001);
    @(negedge CLK);                       // P1
    check("rol_p1_dir", 32'(BS_DIR), 32'd0);
    check("rol_p1_amt", 32'(BS_AMT), 32'd4);
    @(negedge CLK);                       // P2
    check("rol_p2_dir", 32'(BS_DIR), 32'd1);
    check("rol_p2_amt", 32'(BS_AMT), 32'd28);
    check("rol_p2_din", BS_DIN, 32'h8000_0001);
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_req_ready", 32'(REQ_READY), 32'd0);
    check("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("midrst_after_ready", 32'(REQ_READY), 32'd1);
    check("midrst_after_valid", 32'(RSP_VALID), 32'd0);
    check_bs_idle("midrst_after");
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (RSP_VALID) seen++;
    end
    check("midrst_no_stale", 32'(seen), 32'd0);
    send(SLL, 5'd3, 32'h0000_0001);
    wait_rsp(lat);
    got = RSP_DATA;
    check("midrst_sll_data", got, 32'h0000_0008);
    check("midrst_sll_lat", 32'(lat), 32'd2);
    handshake_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
